// File: rtl/prime_pkg.sv
// prime_pkg: shared defaults, FSM encoding and log2 helper for the prime dispatch controller
package prime_pkg;
    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_NUM_TESTERS = 4;
    localparam int DEFAULT_SAVE_CYCLES = 4;
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SPLIT = 3'd1,
        START = 3'd2,
        WAIT  = 3'd3,
        SAVE  = 3'd4
    } state_t;
    function automatic int log2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) r = ((1 << i) < v) ? i + 1 : r;
        return r;
    endfunction
endpackage

// File: rtl/prime_range_split.sv
// prime_range_split: splits divisors 2..floor(n/2) into NUM_TESTERS contiguous half-open slices
module prime_range_split import prime_pkg::*; #(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int NUM_TESTERS = DEFAULT_NUM_TESTERS
) (
    input  logic [WIDTH-1:0]             i_n,
    output logic [NUM_TESTERS*WIDTH-1:0] o_start_val,
    output logic [NUM_TESTERS*WIDTH-1:0] o_end_val,
    output logic [NUM_TESTERS-1:0]       o_en
);
    localparam int L = log2(NUM_TESTERS);
    logic [WIDTH-1:0] w_h;
    logic [WIDTH-1:0] w_b [NUM_TESTERS+1];
    assign w_h = i_n >> 1;
    assign w_b[0] = WIDTH'(2);
    assign w_b[NUM_TESTERS] = w_h + WIDTH'(1);
    // widened product keeps h*k exact before the divide by NUM_TESTERS
    for (genvar k = 1; k < NUM_TESTERS; k++) begin : g_b
        logic [WIDTH-1:0] w_q;
        assign w_q = WIDTH'(((WIDTH+L)'(w_h) * (WIDTH+L)'(k)) >> L);
        assign w_b[k] = (w_q < WIDTH'(2)) ? WIDTH'(2) : w_q;
    end
    for (genvar k = 0; k < NUM_TESTERS; k++) begin : g_o
        assign o_start_val[k*WIDTH +: WIDTH] = w_b[k];
        assign o_end_val[k*WIDTH +: WIDTH] = w_b[k+1];
        assign o_en[k] = w_b[k+1] > w_b[k];
    end
endmodule

// File: rtl/prime_dispatch_ctrl.sv
// prime_dispatch_ctrl: dispatches one candidate to a tester bank, merges verdicts, saves primes
module prime_dispatch_ctrl import prime_pkg::*; #(
    parameter int NUM_TESTERS = DEFAULT_NUM_TESTERS,
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int SAVE_CYCLES = DEFAULT_SAVE_CYCLES
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cand_valid,
    input  logic [WIDTH-1:0]             cand_data,
    output logic                         cand_ready,
    output logic [WIDTH-1:0]             tester_dividend,
    output logic                         tester_start,
    output logic [NUM_TESTERS-1:0]       tester_en,
    output logic [NUM_TESTERS*WIDTH-1:0] tester_start_val,
    output logic [NUM_TESTERS*WIDTH-1:0] tester_end_val,
    input  logic [NUM_TESTERS-1:0]       tester_done,
    input  logic [NUM_TESTERS-1:0]       tester_is_prime,
    output logic                         save,
    output logic [WIDTH-1:0]             data_out,
    output logic                         result_valid,
    output logic                         result_prime,
    output logic [WIDTH-1:0]             prime_count,
    output logic                         busy
);
    localparam int CW = log2(SAVE_CYCLES + 1);
    state_t r_state, w_next;
    logic [WIDTH-1:0] r_n, r_data_out, r_count;
    logic [NUM_TESTERS*WIDTH-1:0] r_start_val, r_end_val, w_start_val, w_end_val;
    logic [NUM_TESTERS-1:0] r_en, w_en;
    logic [CW-1:0] r_cnt;
    logic r_result_valid, r_result_prime;
    logic w_all_done, w_verdict, w_small, w_decide, w_prime, w_enter_save;

    prime_range_split #(.WIDTH(WIDTH), .NUM_TESTERS(NUM_TESTERS)) u_split (
        .i_n(r_n),
        .o_start_val(w_start_val),
        .o_end_val(w_end_val),
        .o_en(w_en)
    );

    assign w_all_done = &(tester_done | ~r_en);
    assign w_verdict = &(tester_is_prime | ~r_en);
    assign w_small = r_n < WIDTH'(2);
    assign w_decide = (r_state == SPLIT && (w_small || w_en == '0)) || (r_state == WAIT && w_all_done);
    assign w_prime = (r_state == SPLIT) ? !w_small : w_verdict;
    assign w_enter_save = (w_next == SAVE) && (r_state != SAVE);

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else r_state <= w_next;
    end

    // first SAVE cycle carries result_valid; the following SAVE_CYCLES cycles strobe save
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = cand_valid ? SPLIT : IDLE;
            SPLIT:   w_next = w_small ? IDLE : (w_en == '0) ? SAVE : START;
            START:   w_next = WAIT;
            WAIT:    w_next = !w_all_done ? WAIT : w_verdict ? SAVE : IDLE;
            SAVE:    w_next = (r_cnt == CW'(SAVE_CYCLES)) ? IDLE : SAVE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_n <= '0;
            r_start_val <= '0;
            r_end_val <= '0;
            r_en <= '0;
            r_data_out <= '0;
            r_count <= '0;
            r_cnt <= '0;
            r_result_valid <= 1'b0;
            r_result_prime <= 1'b0;
        end else begin
            if (r_state == IDLE && cand_valid) r_n <= cand_data;
            if (r_state == SPLIT) begin
                r_start_val <= w_start_val;
                r_end_val <= w_end_val;
                r_en <= w_en;
            end
            if (w_enter_save) begin
                r_data_out <= r_n;
                r_count <= r_count + WIDTH'(1);
            end
            r_cnt <= (r_state == SAVE) ? r_cnt + CW'(1) : '0;
            r_result_valid <= w_decide;
            r_result_prime <= w_decide ? w_prime : r_result_prime;
        end
    end

    assign cand_ready = r_state == IDLE;
    assign busy = ~cand_ready;
    assign tester_dividend = r_n;
    assign tester_start = r_state == START;
    assign tester_en = r_en;
    assign tester_start_val = r_start_val;
    assign tester_end_val = r_end_val;
    assign save = (r_state == SAVE) && (r_cnt != '0);
    assign data_out = r_data_out;
    assign result_valid = r_result_valid;
    assign result_prime = r_result_prime;
    assign prime_count = r_count;
endmodule

// File: doc/prime_dispatch_ctrl.md
Name: prime_dispatch_ctrl

Overview:
- Sits between number_generator and the parallel prime_tester bank on the upstream side, and the serializer on the downstream side.
- Accepts one candidate at a time and splits the divisor range 2..floor(n/2) into NUM_TESTERS contiguous slices.
- Starts the testers, waits for all to finish, and ANDs their verdicts.
- For primes only, drives a save burst into the serializer and counts primes found.

Parameters:
- NUM_TESTERS, 4, number of prime_tester instances; power of 2, at least 2.
- WIDTH, 32, candidate / divisor width.
- SAVE_CYCLES, 4, cycles save is held high (one per serializer byte).

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- cand_valid  input  1  candidate available
- cand_data  input  WIDTH  candidate n
- cand_ready  output  1  controller idle; candidate accepted when valid&ready
- tester_dividend  output  WIDTH  registered n, common to all testers
- tester_start  output  1  one-cycle start pulse, common
- tester_en  output  NUM_TESTERS  per-tester enable; 0 = empty slice, not started
- tester_start_val  output  NUM_TESTERS*WIDTH  slice k low bound (inclusive), slice k at bits [k*WIDTH +: WIDTH]
- tester_end_val  output  NUM_TESTERS*WIDTH  slice k high bound (exclusive)
- tester_done  input  NUM_TESTERS  per-tester done (level)
- tester_is_prime  input  NUM_TESTERS  per-tester verdict, valid when done
- save  output  1  serializer save strobe
- data_out  output  WIDTH  prime being saved; stable while save=1
- result_valid  output  1  one-cycle pulse when a verdict is final
- result_prime  output  1  verdict, valid with result_valid
- prime_count  output  WIDTH  primes found since reset; wraps at 2^WIDTH
- busy  output  1  equals ~cand_ready

Behaviour:
- Reset values: cand_ready=1. All of tester_start, tester_en, save, result_valid, result_prime are 0. tester_dividend, start_val, end_val, data_out and prime_count are 0. FSM goes to IDLE.
- FSM states: IDLE, SPLIT, START, WAIT, SAVE.
- IDLE: cand_ready=1. On cand_valid, register n and go to SPLIT.
- SPLIT (1 cycle): compute h=n>>1 and L=log2(NUM_TESTERS).
  - Boundaries: b0=2; bk=max(2,(h*k)>>L) for 0<k<NUM_TESTERS; bN=h+1.
  - Products use WIDTH+L bits, so there is no overflow.
  - Register start_val[k]=bk, end_val[k]=b(k+1), tester_en[k]=(b(k+1)>b(k)).
  - If n<2: result_prime=0, result_valid pulse, go to IDLE. No testers are started and no save is issued.
  - Else if tester_en is all zero (n=2,3): result_prime=1, result_valid pulse, go to SAVE.
  - Else go to START.
- START (1 cycle): tester_start=1. Go to WAIT.
- WAIT: a slice counts as finished when tester_done[k] OR ~tester_en[k].
  - When all slices are finished: verdict = AND over k of (tester_is_prime[k] OR ~tester_en[k]).
  - Pulse result_valid with result_prime=verdict.
  - Prime: go to SAVE. Composite: go to IDLE.
  - The controller keeps waiting for all slices even if one reports composite early. There is no early abort.
  - done values seen during the START cycle are ignored.
- SAVE: data_out=n, save=1 for exactly SAVE_CYCLES consecutive cycles. prime_count increments once, on entry. Then go to IDLE.
- Latency:
  - Accept to tester_start: 2 cycles.
  - Last done to result_valid: 1 cycle.
  - result_valid to first save cycle: 1 cycle (save rises in the cycle after result_valid).
- Backpressure: cand_ready=0 in every non-IDLE state. cand_valid is ignored there, and the candidate must be held by the source.
- Reset mid-operation, in any state: the next cycle is IDLE with reset values restored. An in-progress save burst is truncated. prime_count is cleared.
- The tester_done/tester_is_prime inputs are level-sensitive. A stale done still high from the previous candidate is masked because it is only sampled in WAIT, after a fresh start.

Decomposition:
- Shared package prime_pkg holds:
  - WIDTH and NUM_TESTERS defaults.
  - FSM state encoding (3-bit localparams IDLE..SAVE).
  - log2 constant function.
- One natural sub-module: prime_range_split. It is combinational: n -> start_val/end_val/tester_en vectors, and is registered in SPLIT by the parent.

Test Plan:
- Reset, then n=97 with a behavioural tester model.
  - Required start/end bounds: [2,12), [12,24), [24,36), [36,49); all en=1.
  - All testers report prime -> result_prime=1, save high 4 cycles with data_out=97, prime_count=1.
- n=91: tester0 reports composite (divisor 7) at cycle 5 while the others finish at cycle 20. result_valid appears only after the last done, with result_prime=0, no save, prime_count unchanged.
- n=1, then n=2.
  - n=1: result_prime=0, tester_start never asserted.
  - n=2: tester_en=0000, result_prime=1, save burst with data_out=2.
- Backpressure: hold cand_valid=1 with n=13, then change to n=17 during WAIT. n=17 is accepted only after return to IDLE, and both saves appear in order 13, 17.
- Assert rst for 1 cycle during the second save cycle for n=29. save drops the next cycle, prime_count=0, cand_ready=1.
- Sweep n=2..100 with testers modelled by true trial division. Exactly 25 save bursts, prime_count=25.
